// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default timing constants.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BRK
    } rx_state_e;

    localparam int OS_DIV_DEF    = 326;
    localparam int OS_RATE_DEF   = 16;
    localparam int DATA_BITS_DEF = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-clk pulse every OS_DIV clocks.
module uart_baud_tick #(
    parameter int OS_DIV = 326
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);
    localparam int CW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CW'(OS_DIV - 1));
    assign cnt_d  = tick_o ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_os16.sv
// 16x-oversampled UART receiver with valid/ready output, framing and overrun flags.
//   state    | meaning
//   ST_IDLE  | line idle, waiting for a falling edge on rxd_s
//   ST_START | counting to mid start bit to confirm it is still low
//   ST_DATA  | sampling payload bits at mid-bit, LSB first
//   ST_STOP  | sampling stop bit; 1 delivers the byte, 0 flags framing error
//   ST_BRK   | line held low after a bad stop bit; wait for it to go high
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int OS_DIV    = OS_DIV_DEF,
    parameter int OS_RATE   = OS_RATE_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err
);
    localparam int SW = $clog2(OS_RATE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] SCNT_HALF = SW'(OS_RATE / 2 - 1);
    localparam logic [SW-1:0] SCNT_LAST = SW'(OS_RATE - 1);
    localparam logic [BW-1:0] BCNT_LAST = BW'(DATA_BITS - 1);

    logic                 tick;
    logic                 rxd_meta_q, rxd_s_q;
    rx_state_e            state_q, state_d;
    logic [SW-1:0]        scnt_q, scnt_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 stop_ok, stop_bad;
    logic                 done_q, ferr_q;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 ovr_q, ovr_d;

    uart_baud_tick #(.OS_DIV(OS_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        scnt_d   = scnt_q;
        bcnt_d   = bcnt_q;
        shreg_d  = shreg_q;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!rxd_s_q) begin
                        state_d = ST_START;
                        scnt_d  = '0;
                    end
                end
                ST_START: begin
                    if (scnt_q == SCNT_HALF) begin
                        scnt_d  = '0;
                        bcnt_d  = '0;
                        state_d = rxd_s_q ? ST_IDLE : ST_DATA;
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
                ST_DATA: begin
                    if (scnt_q == SCNT_LAST) begin
                        shreg_d = {rxd_s_q, shreg_q[DATA_BITS-1:1]};
                        scnt_d  = '0;
                        bcnt_d  = bcnt_q + BW'(1);
                        if (bcnt_q == BCNT_LAST) begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
                ST_STOP: begin
                    if (scnt_q == SCNT_LAST) begin
                        scnt_d   = '0;
                        stop_ok  = rxd_s_q;
                        stop_bad = !rxd_s_q;
                        state_d  = rxd_s_q ? ST_IDLE : ST_BRK;
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
                ST_BRK: begin
                    if (rxd_s_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            scnt_q  <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            done_q  <= stop_ok;
            ferr_q  <= stop_bad;
        end
    end

    // A same-cycle accept frees the holding register, so the new byte replaces it without overrun.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        ovr_d      = 1'b0;
        if (done_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shreg_q;
                rx_valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = ferr_q;
    assign overrun_err = ovr_q;

endmodule
